// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the IF/LS memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_LS = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

  function automatic int starve_w(input int max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_W       = starve_w(STARVE_MAX_DEF);

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating up-counter with clear; clear wins over increment.
module arb_starve_ctr
  import arb_pkg::*;
#(
  parameter int           W   = STARVE_W,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_sat
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = (r_cnt == MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: LS priority, IF starvation guard, one outstanding access.
// Optional wait-cycle performance counters enabled by ARB_PERF_CNT_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_req_ready,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic [31:0]         perf_if_wait,
  output logic [31:0]         perf_ls_wait
);

  localparam int SW = starve_w(STARVE_MAX);

  arb_state_e r_state;
  logic       r_busy;
  logic       r_ls_we;

  logic       w_idle, w_if_pri, w_sel_ls, w_sel_if, w_req;
  logic       w_if_wait, w_ls_wait, w_starve_sat, w_unused;
  logic [SW-1:0] w_starve_cnt;
  arb_owner_e w_win;

  // IF overrides LS only once it has been blocked long enough
  assign w_idle   = (r_state == IDLE);
  assign w_if_pri = if_req_valid & w_starve_sat;
  assign w_sel_ls = w_idle & ls_req_valid & ~w_if_pri;
  assign w_sel_if = w_idle & if_req_valid & ~w_sel_ls;
  assign w_req    = w_sel_ls | w_sel_if;
  assign w_win    = w_sel_ls ? OWN_LS : OWN_IF;

  assign mem_req   = w_req;
  assign mem_we    = w_sel_ls & ls_we;
  assign mem_addr  = w_sel_ls ? ls_addr : (w_sel_if ? if_addr : '0);
  assign mem_wdata = w_sel_ls ? ls_wdata : '0;
  assign mem_be    = w_sel_ls ? ls_be : (w_sel_if ? '1 : '0);

  assign if_req_ready = w_sel_if & mem_gnt;
  assign ls_req_ready = w_sel_ls & mem_gnt;

  // Stores acknowledge with zero data so LS never sees stale read data
  assign if_rsp_valid = (r_state == WAIT_IF) & mem_rvalid;
  assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
  assign ls_rsp_valid = (r_state == WAIT_LS) & mem_rvalid;
  assign ls_rsp_data  = (ls_rsp_valid & ~r_ls_we) ? mem_rdata : '0;

  assign busy = r_busy;

  assign w_if_wait = if_req_valid & ~if_req_ready;
  assign w_ls_wait = ls_req_valid & ~ls_req_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && mem_gnt) begin
            r_state <= (w_win == OWN_LS) ? WAIT_LS : WAIT_IF;
            r_busy  <= 1'b1;
          end
        end
        WAIT_IF, WAIT_LS: begin
          if (mem_rvalid) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ls_req_ready) begin
      r_ls_we <= ls_we;
    end
  end

  arb_starve_ctr #(
    .W   (SW),
    .MAX (SW'(STARVE_MAX))
  ) u_starve (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_if_wait),
    .i_clr (if_req_ready),
    .o_cnt (w_starve_cnt),
    .o_sat (w_starve_sat)
  );

`ifdef ARB_PERF_CNT_EN
  logic w_perf_if_sat, w_perf_ls_sat;

  arb_starve_ctr #(
    .W   (32),
    .MAX (32'hFFFF_FFFF)
  ) u_perf_if (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_if_wait),
    .i_clr (1'b0),
    .o_cnt (perf_if_wait),
    .o_sat (w_perf_if_sat)
  );

  arb_starve_ctr #(
    .W   (32),
    .MAX (32'hFFFF_FFFF)
  ) u_perf_ls (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_ls_wait),
    .i_clr (1'b0),
    .o_cnt (perf_ls_wait),
    .o_sat (w_perf_ls_sat)
  );

  assign w_unused = &{1'b0, w_starve_cnt, w_perf_if_sat, w_perf_ls_sat};
`else
  assign perf_if_wait = '0;
  assign perf_ls_wait = '0;
  assign w_unused     = &{1'b0, w_starve_cnt, w_ls_wait};
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single reads, priority, starvation, stores, reset abort, perf counters.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_be;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [31:0] perf_if_wait;
  logic [31:0] perf_ls_wait;

  int n_chk = 0;
  int n_err = 0;

  mem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_addr      (if_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .ls_req_valid (ls_req_valid),
    .ls_we        (ls_we),
    .ls_addr      (ls_addr),
    .ls_wdata     (ls_wdata),
    .ls_be        (ls_be),
    .ls_req_ready (ls_req_ready),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_data  (ls_rsp_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .perf_if_wait (perf_if_wait),
    .perf_ls_wait (perf_ls_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0;
    if_addr      = '0;
    ls_req_valid = 1'b0;
    ls_we        = 1'b0;
    ls_addr      = '0;
    ls_wdata     = '0;
    ls_be        = '0;
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  logic [7:0]  exp_ifr, exp_lsr, exp_ifrsp, exp_lsrsp;
  logic [31:0] exp_perf;

  initial begin
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_rdy", if_req_ready, 0);
    chk("rst_ls_rsp", ls_rsp_valid, 0);
    chk("rst_perf_if", perf_if_wait, 0);
    chk("rst_perf_ls", perf_ls_wait, 0);

    // rvalid while idle is ignored
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    settle();
    chk("idle_rv_if", if_rsp_valid, 0);
    chk("idle_rv_ls", ls_rsp_valid, 0);
    tick();
    idle_inputs();

    // IF-only read
    if_req_valid = 1'b1;
    if_addr      = 32'h100;
    mem_gnt      = 1'b1;
    settle();
    chk("if1_ready", if_req_ready, 1);
    chk("if1_mem_req", mem_req, 1);
    chk("if1_addr", mem_addr, 32'h100);
    chk("if1_we", mem_we, 0);
    chk("if1_be", mem_be, 4'hF);
    chk("if1_ls_rdy", ls_req_ready, 0);
    tick();
    if_req_valid = 1'b0;
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'hDEAD_BEEF;
    settle();
    chk("if1_rsp_v", if_rsp_valid, 1);
    chk("if1_rsp_d", if_rsp_data, 32'hDEAD_BEEF);
    chk("if1_busy", busy, 1);
    chk("if1_wait_req", mem_req, 0);
    chk("if1_ls_rsp", ls_rsp_valid, 0);
    tick();
    mem_rvalid = 1'b0;
    settle();
    chk("if1_busy_end", busy, 0);
    chk("if1_rsp_end", if_rsp_valid, 0);

    // simultaneous IF and LS load
    do_reset();
    if_req_valid = 1'b1;
    if_addr      = 32'h104;
    ls_req_valid = 1'b1;
    ls_addr      = 32'h40;
    mem_gnt      = 1'b1;
    settle();
    chk("sim_ls_rdy", ls_req_ready, 1);
    chk("sim_if_rdy0", if_req_ready, 0);
    chk("sim_addr_ls", mem_addr, 32'h40);
    tick();
    ls_req_valid = 1'b0;
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'h11;
    settle();
    chk("sim_ls_rsp", ls_rsp_valid, 1);
    chk("sim_ls_data", ls_rsp_data, 32'h11);
    chk("sim_if_wait", if_req_ready, 0);
    tick();
    mem_rvalid = 1'b0;
    settle();
    chk("sim_if_rdy", if_req_ready, 1);
    chk("sim_addr_if", mem_addr, 32'h104);
    tick();
    if_req_valid = 1'b0;
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'h22;
    settle();
    chk("sim_if_rsp", if_rsp_valid, 1);
    chk("sim_if_data", if_rsp_data, 32'h22);
    tick();

    // starvation: LS always valid, IF wins on the third arbitration
    do_reset();
    if_req_valid = 1'b1;
    if_addr      = 32'h200;
    ls_req_valid = 1'b1;
    ls_addr      = 32'h80;
    mem_gnt      = 1'b1;
    exp_ifr   = 8'b0001_0000;
    exp_lsr   = 8'b0100_0101;
    exp_ifrsp = 8'b0010_0000;
    exp_lsrsp = 8'b1000_1010;
    for (int c = 0; c < 8; c++) begin
      mem_rvalid = c[0];
      mem_rdata  = c;
      settle();
      chk($sformatf("stv_if_rdy%0d", c), if_req_ready, exp_ifr[c]);
      chk($sformatf("stv_ls_rdy%0d", c), ls_req_ready, exp_lsr[c]);
      chk($sformatf("stv_if_rsp%0d", c), if_rsp_valid, exp_ifrsp[c]);
      chk($sformatf("stv_ls_rsp%0d", c), ls_rsp_valid, exp_lsrsp[c]);
      tick();
    end

    // store
    do_reset();
    ls_req_valid = 1'b1;
    ls_we        = 1'b1;
    ls_addr      = 32'h2000;
    ls_wdata     = 32'hCAFE_0001;
    ls_be        = 4'b0011;
    mem_gnt      = 1'b1;
    settle();
    chk("st_req", mem_req, 1);
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 32'h2000);
    chk("st_wdata", mem_wdata, 32'hCAFE_0001);
    chk("st_be", mem_be, 4'b0011);
    chk("st_ready", ls_req_ready, 1);
    tick();
    ls_req_valid = 1'b0;
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'h55AA_55AA;
    settle();
    chk("st_rsp_v", ls_rsp_valid, 1);
    chk("st_rsp_d", ls_rsp_data, 0);
    tick();

    // reset while waiting on an LS load
    do_reset();
    ls_req_valid = 1'b1;
    ls_addr      = 32'h3000;
    mem_gnt      = 1'b1;
    tick();
    ls_req_valid = 1'b0;
    mem_gnt      = 1'b0;
    settle();
    chk("rw_busy", busy, 1);
    rst = 1'b0;
    tick();
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    settle();
    chk("rw_ls_rsp", ls_rsp_valid, 0);
    chk("rw_busy0", busy, 0);
    chk("rw_mem_req", mem_req, 0);
    tick();

    // no grant for 7 cycles: winner held, flips to IF once starved
    do_reset();
    if_req_valid = 1'b1;
    if_addr      = 32'h400;
    ls_req_valid = 1'b1;
    ls_addr      = 32'h300;
    mem_gnt      = 1'b0;
    for (int c = 0; c < 7; c++) begin
      settle();
      chk($sformatf("ng_req%0d", c), mem_req, 1);
      chk($sformatf("ng_addr%0d", c), mem_addr, (c < 4) ? 32'h300 : 32'h400);
      chk($sformatf("ng_rdy%0d", c), {if_req_ready, ls_req_ready}, 2'b00);
      tick();
    end
    settle();
`ifdef ARB_PERF_CNT_EN
    exp_perf = 32'd7;
`else
    exp_perf = 32'd0;
`endif
    chk("perf_if", perf_if_wait, exp_perf);
    chk("perf_ls", perf_ls_wait, exp_perf);
    do_reset();
    settle();
    chk("perf_if_clr", perf_if_wait, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
